pipe_dmem_ctrl: RTL and testbench

MEM-stage data-memory controller for the 5-stage pipelined CPU. It consumes the EX/MEM register outputs (mwmem, mm2reg, malu, mb) and runs each load or store as a req/ack transaction on an external data-memory bus. It stalls the front of the pipeline until the access completes, then presents load data (mmo) to the MEM/WB register.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/dmem_watchdog.sv | 38 +++
 rtl/pipe_dmem_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_dmem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM-stage controller state encodings and the
// stall polarity the hazard unit also relies on.
package pipe_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } dmem_state_e;

   localparam logic STALL_ACTIVE = 1'b1;

endpackage

// File: rtl/dmem_watchdog.sv
// Bus watchdog: counts enabled cycles and flags expire on the TIMEOUT-th one.
// Only instantiated when DMEM_TIMEOUT_EN is defined.
module dmem_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic clrn,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Counter saturates at LAST, so expire holds until clr.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/pipe_dmem_ctrl.sv
// MEM-stage data-memory controller: one req/ack bus transaction per load/store,
// stalling the pipeline until done. Optional watchdog under DMEM_TIMEOUT_EN.
module pipe_dmem_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned AW      = 30,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          mwmem,
   input  logic          mm2reg,
   input  logic [31:0]   malu,
   input  logic [31:0]   mb,
   output logic          dm_req,
   output logic          dm_we,
   output logic [AW-1:0] dm_addr,
   output logic [31:0]   dm_wdata,
   input  logic          dm_ack,
   input  logic [31:0]   dm_rdata,
   output logic [31:0]   mmo,
   output logic          mstall,
   output logic          dm_err
);

   dmem_state_e   state_q, state_d;
   logic          acc;
   logic          expire;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mmo_q, mmo_d;

   assign acc = mwmem | mm2reg;

`ifdef DMEM_TIMEOUT_EN
   logic err_q;

   dmem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .clrn   (clrn),
      .clr    (state_q != S_BUSY),
      .en     (state_q == S_BUSY),
      .expire (expire)
   );

   // A real ack in the expiring cycle wins over the timeout.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         err_q <= 1'b0;
      end else if ((state_q == S_BUSY) && !dm_ack && expire) begin
         err_q <= 1'b1;
      end
   end

   assign dm_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign expire         = 1'b0;
   assign dm_err         = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mmo_d   = mmo_q;
      case (state_q)
         S_IDLE: begin
            if (acc) state_d = S_BUSY;
         end
         S_BUSY: begin
            if (dm_ack) begin
               if (!we_q) mmo_d = dm_rdata;
               state_d = S_DONE;
            end else if (expire) begin
               if (!we_q) mmo_d = '0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         mmo_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         mmo_q   <= mmo_d;
         // Bus fields are captured once so EX/MEM churn cannot disturb them.
         if ((state_q == S_IDLE) && acc) begin
            we_q    <= mwmem;
            addr_q  <= malu[AW+1:2];
            wdata_q <= mb;
         end
      end
   end

   logic unused_malu;
   assign unused_malu = ^malu[1:0];

   assign dm_req   = (state_q == S_BUSY);
   assign dm_we    = we_q;
   assign dm_addr  = addr_q;
   assign dm_wdata = wdata_q;
   assign mmo      = mmo_q;
   assign mstall   = (acc && (state_q != S_DONE)) ? STALL_ACTIVE : ~STALL_ACTIVE;

endmodule

// File: tb/tb_pipe_dmem_ctrl.sv
// Self-checking bench for pipe_dmem_ctrl: directed scenarios plus random
// loads/stores checked against a transaction-level model.
module tb_pipe_dmem_ctrl;

   localparam int unsigned AW = 30;

   logic          clk;
   logic          clrn;
   logic          mwmem;
   logic          mm2reg;
   logic [31:0]   malu;
   logic [31:0]   mb;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic          dm_ack;
   logic [31:0]   dm_rdata;
   logic [31:0]   mmo;
   logic          mstall;
   logic          dm_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mmo = '0;
   logic        model_err = 1'b0;

   pipe_dmem_ctrl #(
      .AW      (AW),
      .TIMEOUT (4)
   ) dut (
      .clk      (clk),
      .clrn     (clrn),
      .mwmem    (mwmem),
      .mm2reg   (mm2reg),
      .malu     (malu),
      .mb       (mb),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_ack   (dm_ack),
      .dm_rdata (dm_rdata),
      .mmo      (mmo),
      .mstall   (mstall),
      .dm_err   (dm_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Called #1 after a rising edge with the controller idle. The access is
   // acked on its (wt+1)-th request cycle; EX/MEM data is scrambled meanwhile.
   task automatic run_txn(input logic st, input logic ld, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata,
                          input int wt, input string name);
      logic [29:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_wdata;
      int          stall_cnt = 0;
      int          req_cnt   = 0;
      int          bad       = 0;
      bit          done      = 0;
      exp_addr  = addr[31:2];
      exp_we    = st;
      exp_wdata = data;
      mwmem     = st;
      mm2reg    = ld;
      malu      = addr;
      mb        = data;
      dm_ack    = 1'($urandom_range(0, 1));
      dm_rdata  = $urandom;
      for (int cyc = 0; cyc < wt + 8 && !done; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
            malu     = $urandom;
            mb       = $urandom;
            dm_rdata = $urandom;
            dm_ack   = 1'b0;
            if (dm_req && req_cnt == wt) begin
               dm_ack   = 1'b1;
               dm_rdata = rdata;
            end
         end
         @(negedge clk);
         if (mstall) stall_cnt++;
         if (dm_req) begin
            req_cnt++;
            if (dm_addr !== exp_addr || dm_we !== exp_we || dm_wdata !== exp_wdata) bad++;
         end
         if (!mstall) done = 1;
      end
      if (!st && ld) model_mmo = rdata;
      checks++;
      if (stall_cnt != wt + 2) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, wt + 2);
      end
      checks++;
      if (req_cnt != wt + 1) begin
         errors++;
         $display("FAIL %s req_cycles: got %0d want %0d", name, req_cnt, wt + 1);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s bus_fields: %0d bad cycles, want addr=%h we=%b wdata=%h", name, bad,
                  exp_addr, exp_we, exp_wdata);
      end
      checks++;
      if (mmo !== model_mmo || dm_req !== 1'b0) begin
         errors++;
         $display("FAIL %s done_state: mmo=%h req=%b want mmo=%h req=0", name, mmo, dm_req,
                  model_mmo);
      end
      checks++;
      if (dm_err !== model_err) begin
         errors++;
         $display("FAIL %s dm_err: got %b want %b", name, dm_err, model_err);
      end
      @(posedge clk);
      #1;
      mwmem  = 1'b0;
      mm2reg = 1'b0;
      dm_ack = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (mstall !== 1'b0 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL idle: mstall=%b req=%b want 0 0", mstall, dm_req);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if ({dm_req, dm_we, mstall, dm_err} !== 4'b0 || dm_addr !== '0 || dm_wdata !== '0 ||
          mmo !== '0) begin
         errors++;
         $display("FAIL %s: req=%b we=%b stall=%b err=%b addr=%h wdata=%h mmo=%h want all 0",
                  name, dm_req, dm_we, mstall, dm_err, dm_addr, dm_wdata, mmo);
      end
   endtask

   task automatic test_reset();
      clrn     = 1'b0;
      mwmem    = 1'b0;
      mm2reg   = 1'b0;
      malu     = '0;
      mb       = '0;
      dm_ack   = 1'b0;
      dm_rdata = '0;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_load();
      run_txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, "load_fast");
   endtask

   task automatic test_store();
      run_txn(1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3, "store_wait3");
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'hA5A5_0001, 0, "b2b_load");
      run_txn(1'b1, 1'b0, 32'h0000_0208, 32'h0BAD_CAFE, 32'h0, 0, "b2b_store");
      run_txn(1'b1, 1'b1, 32'h0000_030C, 32'h1111_2222, 32'h3333_4444, 1, "both_is_store");
   endtask

   task automatic test_reset_mid();
      mm2reg = 1'b1;
      malu   = 32'h0000_0040;
      @(posedge clk);
      @(posedge clk);
      #1;
      clrn   = 1'b0;
      mm2reg = 1'b0;
      #1;
      model_mmo = '0;
      model_err = 1'b0;
      check_reset_values("reset_mid");
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;
      run_txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, "load_after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         int          kind;
         logic [31:0] a;
         kind = int'($urandom_range(0, 2));
         a    = $urandom;
         run_txn(kind != 1, kind != 0, a, $urandom, $urandom, int'($urandom_range(0, 5)),
                 "random");
         idle_cycles(int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_timeout();
      int stall_cnt = 0;
      int req_cnt   = 0;
      bit done      = 0;
      mm2reg = 1'b1;
      malu   = 32'h0000_0080;
      dm_ack = 1'b0;
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
            dm_rdata = $urandom;
         end
         @(negedge clk);
         if (mstall) stall_cnt++;
         if (dm_req) req_cnt++;
         if (!mstall) done = 1;
      end
`ifdef DMEM_TIMEOUT_EN
      model_mmo = '0;
      model_err = 1'b1;
      checks++;
      if (stall_cnt != 5 || req_cnt != 4) begin
         errors++;
         $display("FAIL timeout_len: stall=%0d req=%0d want 5 4", stall_cnt, req_cnt);
      end
      checks++;
      if (dm_err !== 1'b1 || mmo !== '0) begin
         errors++;
         $display("FAIL timeout_result: err=%b mmo=%h want 1 0", dm_err, mmo);
      end
      @(posedge clk);
      #1;
      mm2reg = 1'b0;
      idle_cycles(2);
      run_txn(1'b0, 1'b1, 32'h0000_0090, 32'h0, 32'h7777_8888, 1, "after_timeout");
`else
      checks++;
      if (stall_cnt != 30 || req_cnt != 29 || dm_err !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_hang: stall=%0d req=%0d err=%b want 30 29 0", stall_cnt,
                  req_cnt, dm_err);
      end
      @(posedge clk);
      #1;
      dm_ack   = 1'b1;
      dm_rdata = 32'h7777_8888;
      @(posedge clk);
      #1;
      dm_ack    = 1'b0;
      model_mmo = 32'h7777_8888;
      @(negedge clk);
      checks++;
      if (mstall !== 1'b0 || mmo !== model_mmo || dm_req !== 1'b0) begin
         errors++;
         $display("FAIL late_ack: stall=%b mmo=%h req=%b want 0 %h 0", mstall, mmo, dm_req,
                  model_mmo);
      end
      @(posedge clk);
      #1;
      mm2reg = 1'b0;
      idle_cycles(1);
`endif
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
